exp2_pipe: RTL and testbench
============================

EXP2_PIPE -- requirements
Module: exp2_pipe

Interface
REQ-001 Parameter FIX_POINT_WIDTH, default 16, total width W of input and output fixed-point words.
REQ-002 Parameter Bf, default 8, fraction bits of input and output; legal range 2 <= Bf <= W-2.
REQ-003 Parameter ENABLE_CORR, default 1; 1 applies quadratic mantissa correction, 0 gives pure linear 1+v.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  W  signed two's-complement Q(W-Bf).Bf exponent x.
REQ-009 out_valid  output  1  out_data/out_sat valid.
REQ-010 out_ready  input  1  downstream accepts output.
REQ-011 out_data  output  W  unsigned Q(W-Bf).Bf result approximating 2^x.
REQ-012 out_sat  output  1  result clipped to all-ones.

Function
REQ-013 Three-stage pipeline S1 (split), S2 (mantissa), S3 (shift/saturate); each stage holds a valid bit.
REQ-014 Global advance en = ~out_valid | out_ready; in_ready = en; all stages move together when en=1, all hold when en=0.
REQ-015 Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
REQ-016 Latency exactly 3 cycles from input transfer to out_valid with continuous out_ready=1; throughput 1 result/cycle.
REQ-017 Stalled stages hold data and valid unchanged; no transfer lost or duplicated.
REQ-018 S1: u = in_data[W-1:Bf] as signed integer (floor of x); v = in_data[Bf-1:0] as unsigned fraction.
REQ-019 S2 with ENABLE_CORR=0: m = 2^Bf + v (Bf+1 bits).
REQ-020 S2 with ENABLE_CORR=1: p = (v*(2^Bf - v)) >> Bf; corr = (p>>2)+(p>>4)+(p>>5); m = 2^Bf + v - corr, each shift truncating.
REQ-021 S3, u >= 0: r = m << u computed at full width; if r >= 2^W then out_data = all-ones, out_sat = 1, else out_data = r, out_sat = 0.
REQ-022 S3, u < 0: out_data = m >> |u| truncating; |u| >= Bf+1 gives 0; out_sat = 0.
REQ-023 u = most negative value (-2^(W-Bf-1)) handled without magnitude overflow; result 0.
REQ-024 No internal state beyond pipeline registers; no FSM beyond stage valids.

Reset
REQ-025 rst_n low asynchronously clears all stage valids, out_valid=0, out_data=0, out_sat=0.
REQ-026 in_ready is 1 while rst_n is low and on the first cycle after release (pipeline empty).
REQ-027 Reset mid-operation discards all in-flight samples; no output produced for them after release.
REQ-028 Data registers other than outputs need no reset.

Verification (W=16, Bf=8)
REQ-029 ENABLE_CORR=1, in_data 0x0000, 0x0180, 0xFF00 back-to-back, out_ready=1 -> out_data 0x0100, 0x02D4, 0x0080 on cycles 3,4,5, out_sat=0.
REQ-030 ENABLE_CORR=0, in_data 0x0180 then 0x0780 -> out_data 0x0300 then 0xC000; ENABLE_CORR=1, 0x0780 -> 0xB500.
REQ-031 in_data 0x0800 (x=8.0) -> out_data 0xFFFF, out_sat=1; in_data 0x07FF -> out_sat=0, no wrap.
REQ-032 in_data 0xF000 (x=-16) and 0x8000 -> out_data 0x0000, out_sat=0.
REQ-033 Stream 10 random samples, out_ready toggled pseudo-randomly -> in_ready = ~out_valid | out_ready every cycle; outputs in order, match reference model, none dropped or repeated.
REQ-034 Assert rst_n low with 3 samples in flight -> out_valid 0 immediately; after release, next output only from newly accepted input, 3 cycles later.

Source files
------------

// File: rtl/exp2_pipe.sv
// exp2_pipe: three-stage streaming approximation of 2^x for signed fixed-point x.
// S1 splits x into integer part u and fraction v, S2 forms the mantissa
// 1+v (optionally with a quadratic correction), S3 shifts by u and saturates.
module exp2_pipe #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int Bf              = 8,
  parameter int ENABLE_CORR     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] out_data,
  output logic                       out_sat
);

  localparam int W  = FIX_POINT_WIDTH;
  localparam int UW = W - Bf;   // integer-part width
  localparam int MW = Bf + 1;   // mantissa width

  logic en;

  // S1 registers
  logic                 s1_valid;
  logic signed [UW-1:0] s1_u;
  logic [Bf-1:0]        s1_v;

  // S2 registers
  logic                 s2_valid;
  logic signed [UW-1:0] s2_u;
  logic [MW-1:0]        s2_m;

  // S2 combinational terms
  logic [Bf:0]          v_comp;
  logic [2*Bf:0]        prod;
  logic [Bf-1:0]        p;
  logic [Bf-1:0]        corr;
  logic [MW-1:0]        m_next;

  // S3 combinational terms
  logic [UW:0]          mag;
  logic [2*W-1:0]       r_full;
  logic [W-1:0]         res;
  logic                 res_sat;

  // Whole pipeline advances together whenever the output slot is free or drained.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Mantissa: 1+v, minus a scaled v*(1-v) term that bends the linear chord toward 2^v.
  always_comb begin
    v_comp = {1'b1, {Bf{1'b0}}} - {1'b0, s1_v};
    prod   = {{(Bf + 1){1'b0}}, s1_v} * {{Bf{1'b0}}, v_comp};
    // v*(2^Bf - v) < 2^(2Bf-1), so the shifted product always fits in Bf bits.
    p      = Bf'(prod >> Bf);
    corr   = (p >> 2) + (p >> 4) + (p >> 5);
    if (ENABLE_CORR != 0)
      m_next = {1'b1, s1_v} - {1'b0, corr};
    else
      m_next = {1'b1, s1_v};
  end

  // Scale the mantissa by 2^u; positive shifts saturate, negative shifts truncate.
  always_comb begin
    mag     = '0;
    r_full  = '0;
    res     = '0;
    res_sat = 1'b0;
    if (!s2_u[UW-1]) begin
      // m >= 2^Bf, so any u >= W-Bf already overflows; clamping at W keeps r_full finite.
      if (int'(s2_u) >= W) begin
        res     = '1;
        res_sat = 1'b1;
      end else begin
        r_full = (2 * W)'(s2_m) << s2_u;
        if (|r_full[2*W-1:W]) begin
          res     = '1;
          res_sat = 1'b1;
        end else begin
          res = r_full[W-1:0];
        end
      end
    end else begin
      // One extra bit so the most negative u negates without overflow.
      mag = -{s2_u[UW-1], s2_u};
      if (int'(mag) >= Bf + 1)
        res = '0;
      else
        res = W'(s2_m) >> mag;
    end
  end

  // Stage valid bits and output registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_data  <= res;
      out_sat   <= res_sat;
    end
  end

  // Internal data registers move with the valids and need no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_u <= in_data[W-1:Bf];
      s1_v <= in_data[Bf-1:0];
      s2_u <= s1_u;
      s2_m <= m_next;
    end
  end

endmodule

// File: tb/tb_exp2_pipe.sv
// Testbench for exp2_pipe (W=16, Bf=8): a corrected and a linear instance share
// stimulus; expected results are queued on input transfer, popped on output transfer.
module tb_exp2_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_data;
  logic        in_ready_l, out_valid_l, out_sat_l;
  logic [15:0] out_data_l;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  bit in_xfer, out_xfer;

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic [15:0] dl;
    logic        sl;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  exp2_pipe #(.FIX_POINT_WIDTH(16), .Bf(8), .ENABLE_CORR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  exp2_pipe #(.FIX_POINT_WIDTH(16), .Bf(8), .ENABLE_CORR(0)) dut_lin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .out_sat(out_sat_l)
  );

  always #5 clk = ~clk;

  // Reference model: returns {sat, data}.
  function automatic logic [16:0] model(input logic [15:0] x, input bit corr);
    int u, v, p, c, m;
    longint r;
    logic [15:0] lo;
    u = int'($signed(x[15:8]));
    v = int'(x[7:0]);
    p = (v * (256 - v)) / 256;
    c = p / 4 + p / 16 + p / 32;
    m = 256 + v - (corr ? c : 0);
    if (u >= 0) begin
      if (u >= 40) return {1'b1, 16'hFFFF};
      r = longint'(m) << u;
      if (r >= 65536) return {1'b1, 16'hFFFF};
      lo = r[15:0];
      return {1'b0, lo};
    end
    if (-u >= 9) return 17'h0;
    lo = 16'(m >> (-u));
    return {1'b0, lo};
  endfunction

  // One clock cycle: drive inputs after the falling edge, then note which
  // transfers will occur on the coming rising edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    cyc_cnt++;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0, 16'h0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  // Back-to-back known-answer vectors with out_ready held high.
  task automatic test_fixed_vectors;
    typedef struct packed {
      logic [15:0] x; logic [15:0] d; logic s; logic [15:0] dl; logic sl;
    } vec_t;
    vec_t tbl [11] = '{
      '{16'h0000, 16'h0100, 1'b0, 16'h0100, 1'b0},
      '{16'h0180, 16'h02D4, 1'b0, 16'h0300, 1'b0},
      '{16'hFF00, 16'h0080, 1'b0, 16'h0080, 1'b0},
      '{16'h0780, 16'hB500, 1'b0, 16'hC000, 1'b0},
      '{16'h0800, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1},
      '{16'h07FF, 16'hFF80, 1'b0, 16'hFF80, 1'b0},
      '{16'hF000, 16'h0000, 1'b0, 16'h0000, 1'b0},
      '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0},
      '{16'hF880, 16'h0001, 1'b0, 16'h0001, 1'b0},
      '{16'hFC40, 16'h0013, 1'b0, 16'h0014, 1'b0},
      '{16'h7FFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1}
    };
    int k = 0;
    exp_t e;
    for (int i = 0; i < 40 && (k < 11 || exp_q.size() != 0); i++) begin
      cyc(k < 11, (k < 11) ? tbl[k].x : 16'h0, 1'b1);
      if (in_xfer) begin
        exp_q.push_back('{d: tbl[k].d, s: tbl[k].s, dl: tbl[k].dl, sl: tbl[k].sl, cyc: cyc_cnt});
        k++;
      end
      if (out_xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL fixed_unexpected: got output %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.d) begin failures++; $display("FAIL fixed_data: got %h expected %h", out_data, e.d); end
          checks++; if (out_sat !== e.s) begin failures++; $display("FAIL fixed_sat: got %b expected %b", out_sat, e.s); end
          checks++; if (out_data_l !== e.dl) begin failures++; $display("FAIL fixed_lin_data: got %h expected %h", out_data_l, e.dl); end
          checks++; if (out_sat_l !== e.sl) begin failures++; $display("FAIL fixed_lin_sat: got %b expected %b", out_sat_l, e.sl); end
          checks++; if (cyc_cnt - e.cyc !== 3) begin failures++; $display("FAIL fixed_latency: got %0d expected 3", cyc_cnt - e.cyc); end
        end
      end
    end
    checks++;
    if (k != 11 || exp_q.size() != 0) begin
      failures++; $display("FAIL fixed_drain: got %0d sent %0d pending expected 11 sent 0 pending", k, exp_q.size());
    end
  endtask

  // Random stream with random gaps and pseudo-random backpressure.
  task automatic test_backpressure_stream;
    int k = 0;
    logic [15:0] d;
    logic v, r;
    logic [16:0] mc, ml;
    exp_t e;
    d = '0;
    v = 1'b0;
    for (int i = 0; i < 400 && (k < 10 || exp_q.size() != 0); i++) begin
      if (!v && k < 10 && ($urandom_range(0, 3) != 0)) begin
        d = {8'($signed($urandom_range(0, 19)) - 10), 8'($urandom_range(0, 255))};
        v = 1'b1;
      end
      r = ($urandom_range(0, 2) != 0);
      cyc(v, d, r);
      checks++;
      if (in_ready !== (~out_valid | out_ready)) begin
        failures++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, ~out_valid | out_ready);
      end
      if (in_xfer) begin
        mc = model(d, 1'b1);
        ml = model(d, 1'b0);
        exp_q.push_back('{d: mc[15:0], s: mc[16], dl: ml[15:0], sl: ml[16], cyc: cyc_cnt});
        k++;
        v = 1'b0;
      end
      if (out_xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_unexpected: got output %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.d || out_sat !== e.s) begin failures++; $display("FAIL stream_data: got %h/%b expected %h/%b", out_data, out_sat, e.d, e.s); end
          checks++; if (out_data_l !== e.dl || out_sat_l !== e.sl) begin failures++; $display("FAIL stream_lin_data: got %h/%b expected %h/%b", out_data_l, out_sat_l, e.dl, e.sl); end
        end
      end
    end
    checks++;
    if (k != 10 || exp_q.size() != 0) begin
      failures++; $display("FAIL stream_drain: got %0d sent %0d pending expected 10 sent 0 pending", k, exp_q.size());
    end
  endtask

  // Reset with samples in flight; only a fresh sample may come out afterwards.
  task automatic test_reset_in_flight;
    exp_t e;
    bit seen = 1'b0;
    cyc(1'b1, 16'h0000, 1'b1);
    cyc(1'b1, 16'h0180, 1'b1);
    cyc(1'b1, 16'hFF00, 1'b1);
    @(posedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL inflight_in_ready: got %b expected 1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inflight_stale_output: got out_valid %b expected 0", out_valid); end
    end
    cyc(1'b1, 16'h0780, 1'b1);
    if (in_xfer) exp_q.push_back('{d: 16'hB500, s: 1'b0, dl: 16'hC000, sl: 1'b0, cyc: cyc_cnt});
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      if (out_xfer) begin
        seen = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL inflight_unexpected: got output %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.d) begin failures++; $display("FAIL inflight_data: got %h expected %h", out_data, e.d); end
          checks++; if (cyc_cnt - e.cyc !== 3) begin failures++; $display("FAIL inflight_latency: got %0d expected 3", cyc_cnt - e.cyc); end
        end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL inflight_timeout: got no output expected one"); end
  endtask

  initial begin
    test_reset;
    test_fixed_vectors;
    test_backpressure_stream;
    test_reset_in_flight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
